// File: rtl/sad_core_pkg.sv
// Shared types and encodings for the SAD core ID stage:
// ALU op codes, MIPS opcode/funct constants, decoded control bundle.
package sad_core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOR, ALU_XOR, ALU_SLT, ALU_SLTU,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_LUI, ALU_MUL, ALU_PASS_B
    } alu_op_e;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_CUSTOM = 6'h1C;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [5:0] C_MUL          = 6'h02;
    localparam logic [5:0] C_FRAME_SHIFT  = 6'h10;
    localparam logic [5:0] C_WINDOW_SHIFT = 6'h11;
    localparam logic [5:0] C_MIN_IN       = 6'h12;
    localparam logic [5:0] C_BUFF         = 6'h13;
    localparam logic [5:0] C_LOAD_BUFF_A  = 6'h14;
    localparam logic [5:0] C_LOAD_BUFF_B  = 6'h15;
    localparam logic [5:0] C_LOAD_MIN     = 6'h16;

    typedef struct packed {
        logic    r;
        logic    reg_write;
        logic    mem_write;
        logic    mem_read;
        logic    half_op;
        logic    byte_op;
        logic    jal;
        logic    use_rs;
        logic    use_rt;
        logic    zext;
        logic    branch_eq;
        logic    branch_ne;
        logic    jump;
        logic    jump_reg;
        logic    frame_shift;
        logic    window_shift;
        logic    min_in;
        logic    buff;
        logic    load_buff_a;
        logic    load_buff_b;
        logic    load_min;
        alu_op_e alu;
    } ctrl_t;

    function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        unique case (op)
            OP_RTYPE: begin
                c.r = 1'b1; c.reg_write = 1'b1;
                c.use_rs = 1'b1; c.use_rt = 1'b1;
                unique case (fn)
                    F_SLL:          begin c.alu = ALU_SLL; c.use_rs = 1'b0; end
                    F_SRL:          begin c.alu = ALU_SRL; c.use_rs = 1'b0; end
                    F_SRA:          begin c.alu = ALU_SRA; c.use_rs = 1'b0; end
                    F_SLLV:         c.alu = ALU_SLLV;
                    F_SRLV:         c.alu = ALU_SRLV;
                    F_JR: begin
                        c.r = 1'b0; c.reg_write = 1'b0;
                        c.use_rt = 1'b0; c.jump_reg = 1'b1;
                    end
                    F_ADD, F_ADDU:  c.alu = ALU_ADD;
                    F_SUB, F_SUBU:  c.alu = ALU_SUB;
                    F_AND:          c.alu = ALU_AND;
                    F_OR:           c.alu = ALU_OR;
                    F_XOR:          c.alu = ALU_XOR;
                    F_NOR:          c.alu = ALU_NOR;
                    F_SLT:          c.alu = ALU_SLT;
                    F_SLTU:         c.alu = ALU_SLTU;
                    default:        c = '0;
                endcase
            end
            OP_CUSTOM: begin
                c.use_rs = 1'b1; c.use_rt = 1'b1;
                unique case (fn)
                    C_MUL: begin
                        c.r = 1'b1; c.reg_write = 1'b1; c.alu = ALU_MUL;
                    end
                    C_FRAME_SHIFT:  c.frame_shift = 1'b1;
                    C_WINDOW_SHIFT: c.window_shift = 1'b1;
                    C_MIN_IN:       c.min_in = 1'b1;
                    C_BUFF:         c.buff = 1'b1;
                    C_LOAD_BUFF_A:  c.load_buff_a = 1'b1;
                    C_LOAD_BUFF_B:  c.load_buff_b = 1'b1;
                    C_LOAD_MIN: begin
                        c.load_min = 1'b1; c.r = 1'b1; c.reg_write = 1'b1;
                    end
                    default:        c = '0;
                endcase
            end
            OP_J:   c.jump = 1'b1;
            OP_JAL: begin
                c.jump = 1'b1; c.jal = 1'b1; c.r = 1'b1; c.reg_write = 1'b1;
            end
            OP_BEQ: begin
                c.branch_eq = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.alu = ALU_SUB;
            end
            OP_BNE: begin
                c.branch_ne = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1; c.alu = ALU_SUB;
            end
            OP_ADDI, OP_ADDIU: begin c.reg_write = 1'b1; c.use_rs = 1'b1; end
            OP_SLTI:  begin c.reg_write = 1'b1; c.use_rs = 1'b1; c.alu = ALU_SLT; end
            OP_SLTIU: begin c.reg_write = 1'b1; c.use_rs = 1'b1; c.alu = ALU_SLTU; end
            OP_ANDI: begin
                c.reg_write = 1'b1; c.use_rs = 1'b1; c.zext = 1'b1; c.alu = ALU_AND;
            end
            OP_ORI: begin
                c.reg_write = 1'b1; c.use_rs = 1'b1; c.zext = 1'b1; c.alu = ALU_OR;
            end
            OP_XORI: begin
                c.reg_write = 1'b1; c.use_rs = 1'b1; c.zext = 1'b1; c.alu = ALU_XOR;
            end
            OP_LUI: begin c.reg_write = 1'b1; c.alu = ALU_LUI; end
            OP_LB, OP_LH, OP_LW: begin
                c.reg_write = 1'b1; c.mem_read = 1'b1; c.use_rs = 1'b1;
                c.byte_op = (op == OP_LB); c.half_op = (op == OP_LH);
            end
            OP_SB, OP_SH, OP_SW: begin
                c.mem_write = 1'b1; c.use_rs = 1'b1; c.use_rt = 1'b1;
                c.byte_op = (op == OP_SB); c.half_op = (op == OP_SH);
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/buf_reg.sv
// Inter-core buffer register: rs/rt snapshot plus a valid flag.
// A set in the same cycle as a clear keeps the flag high.
module buf_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set,
    input  logic        clr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] val_1,
    output logic [31:0] val_2,
    output logic        flag
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_1 <= '0;
            val_2 <= '0;
            flag  <= 1'b0;
        end else if (set) begin
            val_1 <= rs_val;
            val_2 <= rt_val;
            flag  <= 1'b1;
        end else if (clr) begin
            flag  <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_decode_unit.sv
// ID stage of the 6-stage SAD core: regfile, decode, RAW stall,
// branch/jump resolution and the inter-core buffer register.
module instruction_decode_unit
    import sad_core_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IF_ID_Instruction,
    input  logic [31:0] IF_ID_PC4,
    input  logic [31:0] WB_WriteData,
    input  logic [4:0]  MEM_WB_WriteRegister,
    input  logic        MEM_WB_RegWrite,
    input  logic        ID_EX_RegWrite,
    input  logic        EX_MEM_RegWrite,
    input  logic        MEM_SAD_RegWrite,
    input  logic [4:0]  EX_WriteRegister,
    input  logic [4:0]  EX_MEM_WriteRegister,
    input  logic [4:0]  MEM_SAD_WriteRegister,
    input  logic        all_buf_flags,
    output logic [31:0] ID_rs_val,
    output logic [31:0] ID_rt_val,
    output logic [31:0] ID_ext_imm,
    output logic [31:0] ID_new_PC,
    output logic [4:0]  ID_rt,
    output logic [4:0]  ID_rd,
    output logic [4:0]  ID_shamt,
    output logic [3:0]  ID_ALUControl,
    output logic        ID_R,
    output logic        ID_RegWrite,
    output logic        ID_MemWrite,
    output logic        ID_MemRead,
    output logic        ID_HalfControl,
    output logic        ID_ByteControl,
    output logic        ID_JALControl,
    output logic        ID_PCSrc,
    output logic        ID_stall,
    output logic        ID_frame_shift,
    output logic        ID_window_shift,
    output logic        ID_min_in,
    output logic        ID_buff,
    output logic        ID_load_buff_a,
    output logic        ID_load_buff_b,
    output logic        ID_load_min,
    output logic        ID_load_min_tag,
    output logic [31:0] buf_val_1,
    output logic [31:0] buf_val_2,
    output logic        buf_flag
);

    logic [31:0] regs [32];
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt;
    logic [15:0] imm;
    logic [31:0] sext_imm;
    logic [31:0] br_target;
    logic        rs_hit, rt_hit, taken;
    ctrl_t       c;

    assign op  = IF_ID_Instruction[31:26];
    assign rs  = IF_ID_Instruction[25:21];
    assign rt  = IF_ID_Instruction[20:16];
    assign fn  = IF_ID_Instruction[5:0];
    assign imm = IF_ID_Instruction[15:0];
    assign c   = decode(op, fn);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (MEM_WB_RegWrite && MEM_WB_WriteRegister != 5'd0) begin
            regs[MEM_WB_WriteRegister] <= WB_WriteData;
        end
    end

    // WB write in the same cycle is visible to the read without waiting a cycle.
    always_comb begin
        ID_rs_val = regs[rs];
        if (rs == 5'd0)
            ID_rs_val = '0;
        else if (MEM_WB_RegWrite && MEM_WB_WriteRegister == rs)
            ID_rs_val = WB_WriteData;
        ID_rt_val = regs[rt];
        if (rt == 5'd0)
            ID_rt_val = '0;
        else if (MEM_WB_RegWrite && MEM_WB_WriteRegister == rt)
            ID_rt_val = WB_WriteData;
    end

    assign rs_hit = (rs != 5'd0) &&
        ((ID_EX_RegWrite   && EX_WriteRegister      == rs) ||
         (EX_MEM_RegWrite  && EX_MEM_WriteRegister  == rs) ||
         (MEM_SAD_RegWrite && MEM_SAD_WriteRegister == rs));
    assign rt_hit = (rt != 5'd0) &&
        ((ID_EX_RegWrite   && EX_WriteRegister      == rt) ||
         (EX_MEM_RegWrite  && EX_MEM_WriteRegister  == rt) ||
         (MEM_SAD_RegWrite && MEM_SAD_WriteRegister == rt));

    assign ID_stall = (c.use_rs && rs_hit) || (c.use_rt && rt_hit) ||
        ((c.load_buff_a || c.load_buff_b) && !all_buf_flags);

    assign sext_imm   = {{16{imm[15]}}, imm};
    assign ID_ext_imm = c.zext ? {16'h0000, imm} : sext_imm;
    assign br_target  = IF_ID_PC4 + {sext_imm[29:0], 2'b00};

    assign taken = (c.branch_eq && ID_rs_val == ID_rt_val) ||
                   (c.branch_ne && ID_rs_val != ID_rt_val) ||
                   c.jump || c.jump_reg;

    always_comb begin
        unique case (1'b1)
            c.jump:     ID_new_PC = {IF_ID_PC4[31:28], IF_ID_Instruction[25:0], 2'b00};
            c.jump_reg: ID_new_PC = ID_rs_val;
            default:    ID_new_PC = br_target;
        endcase
    end

    assign ID_rt           = rt;
    assign ID_rd           = c.jal ? 5'd31 : IF_ID_Instruction[15:11];
    assign ID_shamt        = IF_ID_Instruction[10:6];
    assign ID_ALUControl   = c.alu;
    assign ID_R            = c.r;
    assign ID_RegWrite     = c.reg_write && !ID_stall;
    assign ID_MemWrite     = c.mem_write && !ID_stall;
    assign ID_MemRead      = c.mem_read;
    assign ID_HalfControl  = c.half_op;
    assign ID_ByteControl  = c.byte_op;
    assign ID_JALControl   = c.jal;
    assign ID_PCSrc        = taken && !ID_stall;
    assign ID_frame_shift  = c.frame_shift;
    assign ID_window_shift = c.window_shift;
    assign ID_min_in       = c.min_in;
    assign ID_buff         = c.buff && !ID_stall;
    assign ID_load_buff_a  = c.load_buff_a;
    assign ID_load_buff_b  = c.load_buff_b;
    assign ID_load_min     = c.load_min;
    assign ID_load_min_tag = c.load_min;

    buf_reg u_buf_reg (
        .clk    (Clk),
        .rst_n  (Reset),
        .set    (ID_buff),
        .clr    ((c.load_buff_a || c.load_buff_b) && !ID_stall),
        .rs_val (ID_rs_val),
        .rt_val (ID_rt_val),
        .val_1  (buf_val_1),
        .val_2  (buf_val_2),
        .flag   (buf_flag)
    );

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Directed-vector bench for instruction_decode_unit with
// hand-computed expectations.
module tb_instruction_decode_unit;

    logic        Clk, Reset;
    logic [31:0] IF_ID_Instruction, IF_ID_PC4, WB_WriteData;
    logic [4:0]  MEM_WB_WriteRegister;
    logic        MEM_WB_RegWrite, ID_EX_RegWrite, EX_MEM_RegWrite, MEM_SAD_RegWrite;
    logic [4:0]  EX_WriteRegister, EX_MEM_WriteRegister, MEM_SAD_WriteRegister;
    logic        all_buf_flags;
    logic [31:0] ID_rs_val, ID_rt_val, ID_ext_imm, ID_new_PC;
    logic [4:0]  ID_rt, ID_rd, ID_shamt;
    logic [3:0]  ID_ALUControl;
    logic        ID_R, ID_RegWrite, ID_MemWrite, ID_MemRead, ID_HalfControl;
    logic        ID_ByteControl, ID_JALControl, ID_PCSrc, ID_stall;
    logic        ID_frame_shift, ID_window_shift, ID_min_in, ID_buff;
    logic        ID_load_buff_a, ID_load_buff_b, ID_load_min, ID_load_min_tag;
    logic [31:0] buf_val_1, buf_val_2;
    logic        buf_flag;

    int total = 0;
    int bad   = 0;

    instruction_decode_unit dut (
        .Clk(Clk), .Reset(Reset),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC4(IF_ID_PC4),
        .WB_WriteData(WB_WriteData), .MEM_WB_WriteRegister(MEM_WB_WriteRegister),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .MEM_SAD_RegWrite(MEM_SAD_RegWrite),
        .EX_WriteRegister(EX_WriteRegister), .EX_MEM_WriteRegister(EX_MEM_WriteRegister),
        .MEM_SAD_WriteRegister(MEM_SAD_WriteRegister), .all_buf_flags(all_buf_flags),
        .ID_rs_val(ID_rs_val), .ID_rt_val(ID_rt_val), .ID_ext_imm(ID_ext_imm),
        .ID_new_PC(ID_new_PC), .ID_rt(ID_rt), .ID_rd(ID_rd), .ID_shamt(ID_shamt),
        .ID_ALUControl(ID_ALUControl), .ID_R(ID_R), .ID_RegWrite(ID_RegWrite),
        .ID_MemWrite(ID_MemWrite), .ID_MemRead(ID_MemRead),
        .ID_HalfControl(ID_HalfControl), .ID_ByteControl(ID_ByteControl),
        .ID_JALControl(ID_JALControl), .ID_PCSrc(ID_PCSrc), .ID_stall(ID_stall),
        .ID_frame_shift(ID_frame_shift), .ID_window_shift(ID_window_shift),
        .ID_min_in(ID_min_in), .ID_buff(ID_buff), .ID_load_buff_a(ID_load_buff_a),
        .ID_load_buff_b(ID_load_buff_b), .ID_load_min(ID_load_min),
        .ID_load_min_tag(ID_load_min_tag), .buf_val_1(buf_val_1),
        .buf_val_2(buf_val_2), .buf_flag(buf_flag)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] cins(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
        return {6'h1C, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        MEM_WB_WriteRegister = a;
        WB_WriteData         = d;
        MEM_WB_RegWrite      = 1'b1;
        cyc();
        MEM_WB_RegWrite      = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        IF_ID_Instruction = '0; IF_ID_PC4 = '0; WB_WriteData = '0;
        MEM_WB_WriteRegister = '0; MEM_WB_RegWrite = 1'b0;
        ID_EX_RegWrite = 1'b0; EX_MEM_RegWrite = 1'b0; MEM_SAD_RegWrite = 1'b0;
        EX_WriteRegister = '0; EX_MEM_WriteRegister = '0; MEM_SAD_WriteRegister = '0;
        all_buf_flags = 1'b0;
        cyc(); cyc();
        Reset = 1'b1;

        // fill state, then reset must clear it
        wb(5'd5, 32'h0000_AAAA);
        wb(5'd6, 32'h0000_5555);
        IF_ID_Instruction = cins(5, 6, 0, 6'h13); #1;
        chk("buff_strobe", ID_buff, 1);
        cyc();
        IF_ID_Instruction = '0; #1;
        chk("pre_rst_val1", buf_val_1, 32'h0000_AAAA);
        chk("pre_rst_flag", buf_flag, 1);
        Reset = 1'b0;
        cyc();
        Reset = 1'b1;
        IF_ID_Instruction = rins(5, 6, 7, 6'h21); #1;
        chk("rst_rs", ID_rs_val, 0);
        chk("rst_rt", ID_rt_val, 0);
        chk("rst_flag", buf_flag, 0);
        chk("rst_val1", buf_val_1, 0);
        chk("rst_val2", buf_val_2, 0);

        // WB bypass
        MEM_WB_WriteRegister = 5'd8; WB_WriteData = 32'h1234; MEM_WB_RegWrite = 1'b1;
        IF_ID_Instruction = rins(8, 0, 9, 6'h21); #1;
        chk("byp_rs", ID_rs_val, 32'h1234);
        chk("byp_stall", ID_stall, 0);
        chk("addu_rw", ID_RegWrite, 1);
        chk("addu_r", ID_R, 1);
        chk("addu_rd", ID_rd, 9);
        chk("addu_alu", ID_ALUControl, 0);
        cyc();
        MEM_WB_RegWrite = 1'b0; #1;
        chk("rf_rs", ID_rs_val, 32'h1234);

        // $0 is hardwired
        MEM_WB_WriteRegister = 5'd0; WB_WriteData = 32'hFFFF_FFFF; MEM_WB_RegWrite = 1'b1;
        IF_ID_Instruction = rins(0, 8, 9, 6'h21); #1;
        chk("r0_byp", ID_rs_val, 0);
        chk("r0_rt", ID_rt_val, 32'h1234);
        cyc();
        MEM_WB_RegWrite = 1'b0; #1;
        chk("r0_keep", ID_rs_val, 0);

        // RAW hazards
        ID_EX_RegWrite = 1'b1; EX_WriteRegister = 5'd8;
        IF_ID_Instruction = rins(8, 0, 9, 6'h21); #1;
        chk("haz_ex", ID_stall, 1);
        chk("haz_rw", ID_RegWrite, 0);
        IF_ID_Instruction = iins(6'h04, 8, 8, 16'd3); #1;
        chk("haz_beq_stall", ID_stall, 1);
        chk("haz_pcsrc", ID_PCSrc, 0);
        EX_WriteRegister = 5'd0;
        IF_ID_Instruction = rins(0, 0, 9, 6'h21); #1;
        chk("haz_r0", ID_stall, 0);
        ID_EX_RegWrite = 1'b0;
        EX_MEM_RegWrite = 1'b1; EX_MEM_WriteRegister = 5'd8;
        IF_ID_Instruction = rins(0, 8, 9, 6'h21); #1;
        chk("haz_exmem_rt", ID_stall, 1);
        EX_MEM_RegWrite = 1'b0;
        MEM_SAD_WriteRegister = 5'd8; #1;
        chk("haz_sad_off", ID_stall, 0);
        MEM_SAD_RegWrite = 1'b1; #1;
        chk("haz_sad_on", ID_stall, 1);
        IF_ID_Instruction = iins(6'h09, 0, 8, 16'd5); #1;
        chk("haz_rt_dest", ID_stall, 0);
        chk("addiu_imm", ID_ext_imm, 5);
        MEM_SAD_RegWrite = 1'b0;

        // branches
        IF_ID_Instruction = '0;
        wb(5'd1, 32'd5);
        wb(5'd2, 32'd5);
        IF_ID_PC4 = 32'h100;
        IF_ID_Instruction = iins(6'h04, 1, 2, 16'd3); #1;
        chk("beq_pcsrc", ID_PCSrc, 1);
        chk("beq_pc", ID_new_PC, 32'h10C);
        IF_ID_Instruction = iins(6'h05, 1, 2, 16'd3); #1;
        chk("bne_nt", ID_PCSrc, 0);
        IF_ID_Instruction = iins(6'h04, 1, 2, 16'hFFFF); #1;
        chk("beq_back", ID_new_PC, 32'hFC);
        IF_ID_Instruction = '0;
        wb(5'd2, 32'd6);
        IF_ID_Instruction = iins(6'h05, 1, 2, 16'd3); #1;
        chk("bne_t", ID_PCSrc, 1);
        chk("bne_pc", ID_new_PC, 32'h10C);

        // buffer register
        IF_ID_Instruction = '0;
        wb(5'd3, 32'd7);
        wb(5'd4, 32'd9);
        IF_ID_Instruction = cins(3, 4, 0, 6'h13); #1;
        cyc();
        IF_ID_Instruction = '0; #1;
        chk("buf_v1", buf_val_1, 7);
        chk("buf_v2", buf_val_2, 9);
        chk("buf_set", buf_flag, 1);
        all_buf_flags = 1'b0;
        IF_ID_Instruction = cins(0, 0, 0, 6'h14); #1;
        chk("lba_stall", ID_stall, 1);
        cyc();
        chk("lba_hold", buf_flag, 1);
        all_buf_flags = 1'b1; #1;
        chk("lba_go", ID_stall, 0);
        chk("lba_strobe", ID_load_buff_a, 1);
        cyc();
        IF_ID_Instruction = '0; #1;
        chk("lba_clr", buf_flag, 0);

        // jumps
        IF_ID_PC4 = 32'h0000_0104;
        IF_ID_Instruction = {6'h03, 26'h40}; #1;
        chk("jal_pc", ID_new_PC, 32'h100);
        chk("jal_rd", ID_rd, 31);
        chk("jal_ctl", ID_JALControl, 1);
        chk("jal_rw", ID_RegWrite, 1);
        chk("jal_pcsrc", ID_PCSrc, 1);
        IF_ID_Instruction = rins(3, 0, 0, 6'h08); #1;
        chk("jr_pc", ID_new_PC, 7);
        chk("jr_rw", ID_RegWrite, 0);

        // immediates, memory, custom, undefined
        IF_ID_Instruction = iins(6'h0C, 0, 1, 16'h8000); #1;
        chk("andi_zext", ID_ext_imm, 32'h0000_8000);
        IF_ID_Instruction = iins(6'h08, 0, 1, 16'h8000); #1;
        chk("addi_sext", ID_ext_imm, 32'hFFFF_8000);
        IF_ID_Instruction = iins(6'h21, 1, 2, 16'd0); #1;
        chk("lh_half", ID_HalfControl, 1);
        chk("lh_rd", ID_MemRead, 1);
        IF_ID_Instruction = iins(6'h28, 1, 2, 16'd0); #1;
        chk("sb_byte", ID_ByteControl, 1);
        chk("sb_wr", ID_MemWrite, 1);
        IF_ID_Instruction = cins(0, 0, 12, 6'h16); #1;
        chk("lmin", ID_load_min, 1);
        chk("lmin_tag", ID_load_min_tag, 1);
        chk("lmin_rd", ID_rd, 12);
        chk("lmin_rw", ID_RegWrite, 1);
        IF_ID_Instruction = 32'hFC00_0000; #1;
        chk("undef_rw", ID_RegWrite, 0);
        chk("undef_mw", ID_MemWrite, 0);
        chk("undef_pcsrc", ID_PCSrc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
